// File: rtl/emif_bram_bridge_if.sv
// EMIF1 / BRAM port B signal bundle for the EMIF-to-BRAM bridge.
// master = EMIF controller + BRAM side, slave = bridge.
interface emif_bram_bridge_if;
  logic [8:0]  EMIF_A;
  logic        EMIF_RAS_N;
  logic        EMIF_CAS_N;
  logic        EMIF_WEN_N;
  logic [15:0] EMIF_D_IN;
  logic [15:0] EMIF_D_OUT;
  logic        EMIF_D_OE;
  logic [31:0] BRAM_ADDR;
  logic [31:0] BRAM_DIN;
  logic [31:0] BRAM_DOUT;
  logic        BRAM_EN;
  logic        BRAM_WE;
  logic        PL_IRQ;
  logic        PACK_ERR;
  logic [7:0]  DOORBELL_CNT;

  modport master (
    output EMIF_A, EMIF_RAS_N, EMIF_CAS_N, EMIF_WEN_N, EMIF_D_IN, BRAM_DOUT,
    input  EMIF_D_OUT, EMIF_D_OE, BRAM_ADDR, BRAM_DIN, BRAM_EN, BRAM_WE,
           PL_IRQ, PACK_ERR, DOORBELL_CNT
  );

  modport slave (
    input  EMIF_A, EMIF_RAS_N, EMIF_CAS_N, EMIF_WEN_N, EMIF_D_IN, BRAM_DOUT,
    output EMIF_D_OUT, EMIF_D_OE, BRAM_ADDR, BRAM_DIN, BRAM_EN, BRAM_WE,
           PL_IRQ, PACK_ERR, DOORBELL_CNT
  );
endinterface

// File: rtl/emif_bram_bridge.sv
// EMIF1 SDRAM-style bus to 32-bit BRAM port B bridge: half-word packing,
// fixed-CAS-latency read return, and a doorbell interrupt pulse.
module emif_bram_bridge #(
  parameter int                 ROW_W         = 2,
  parameter int                 CL            = 3,
  parameter logic [ROW_W+7:0]   DOORBELL_ADDR = '1,
  parameter int                 IRQ_PULSE     = 4
) (
  input logic               CLOCK,
  input logic               RESET,
  emif_bram_bridge_if.slave bus
);
  localparam int AW     = ROW_W + 8;
  localparam int STAGES = CL - 1;

  typedef enum logic [1:0] {CMD_NOP, CMD_ACT, CMD_RD, CMD_WR} cmd_e;

  cmd_e            cmd;
  logic [ROW_W-1:0] row;
  logic [AW-1:0]   word_addr;
  logic            hsel;
  logic [15:0]     hold;
  logic [AW-1:0]   hold_addr;
  logic            hold_valid;
  logic            pair_ok;
  logic            pack_err;
  logic            bram_en, bram_we;
  logic [AW-1:0]   bram_word;
  logic [31:0]     bram_din;
  logic [STAGES:0] vld_pipe;
  logic [1:0]      hsel_pipe;
  logic [CL-3:0][15:0] dat_pipe;
  logic [7:0]      irq_cnt;
  logic [7:0]      db_cnt;
  logic            db_hit;

  // Refresh / mode-register (RAS+CAS both low) fall through to NOP.
  always_comb begin
    cmd = CMD_NOP;
    unique case ({bus.EMIF_RAS_N, bus.EMIF_CAS_N})
      2'b01:   cmd = CMD_ACT;
      2'b10:   cmd = bus.EMIF_WEN_N ? CMD_RD : CMD_WR;
      default: cmd = CMD_NOP;
    endcase
  end

  assign word_addr = {row, bus.EMIF_A[8:1]};
  assign hsel      = bus.EMIF_A[0];
  assign pair_ok   = hold_valid && (hold_addr == word_addr);

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      row        <= '0;
      hold       <= '0;
      hold_addr  <= '0;
      hold_valid <= 1'b0;
      pack_err   <= 1'b0;
      bram_en    <= 1'b0;
      bram_we    <= 1'b0;
      bram_word  <= '0;
      bram_din   <= '0;
    end else begin
      bram_en <= 1'b0;
      bram_we <= 1'b0;
      unique case (cmd)
        CMD_ACT: row <= bus.EMIF_A[ROW_W-1:0];
        CMD_RD: begin
          bram_en   <= 1'b1;
          bram_word <= word_addr;
        end
        CMD_WR: begin
          if (!hsel) begin
            // Low half parks in the hold register until its high half arrives.
            hold       <= bus.EMIF_D_IN;
            hold_addr  <= word_addr;
            hold_valid <= 1'b1;
            if (hold_valid) pack_err <= 1'b1;
          end else begin
            bram_en   <= 1'b1;
            bram_we   <= 1'b1;
            bram_word <= word_addr;
            if (pair_ok) begin
              bram_din   <= {bus.EMIF_D_IN, hold};
              hold_valid <= 1'b0;
            end else begin
              bram_din <= {bus.EMIF_D_IN, 16'h0000};
              pack_err <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // vld_pipe[k] is set k edges after the READ edge; the last stage is OE.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      vld_pipe  <= '0;
      hsel_pipe <= '0;
      dat_pipe  <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[STAGES-1:0], cmd == CMD_RD};
      hsel_pipe <= {hsel_pipe[0], hsel};
      dat_pipe[0] <= hsel_pipe[1] ? bus.BRAM_DOUT[31:16] : bus.BRAM_DOUT[15:0];
      for (int k = 1; k <= CL-3; k++) dat_pipe[k] <= dat_pipe[k-1];
    end
  end

  // Doorbell fires when the write actually reaches BRAM, one edge after decode.
  assign db_hit = bram_en && bram_we && (bram_word == DOORBELL_ADDR);

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      irq_cnt <= '0;
      db_cnt  <= '0;
    end else begin
      if (db_hit) begin
        irq_cnt <= 8'(IRQ_PULSE);
        db_cnt  <= db_cnt + 8'd1;
      end else if (irq_cnt != 8'd0) begin
        irq_cnt <= irq_cnt - 8'd1;
      end
    end
  end

  assign bus.EMIF_D_OUT   = dat_pipe[CL-3];
  assign bus.EMIF_D_OE    = vld_pipe[STAGES];
  assign bus.BRAM_ADDR    = {{(30-AW){1'b0}}, bram_word, 2'b00};
  assign bus.BRAM_DIN     = bram_din;
  assign bus.BRAM_EN      = bram_en;
  assign bus.BRAM_WE      = bram_we;
  assign bus.PL_IRQ       = (irq_cnt != 8'd0);
  assign bus.PACK_ERR     = pack_err;
  assign bus.DOORBELL_CNT = db_cnt;
endmodule

// File: tb/tb_emif_bram_bridge.sv
// Directed bench for emif_bram_bridge: reference model of packing, read
// scoreboard with cycle-exact OE timing, and doorbell pulse window tracking.
module tb_emif_bram_bridge;
  localparam int CL        = 3;
  localparam int IRQ_PULSE = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  emif_bram_bridge_if bus();

  emif_bram_bridge #(
    .ROW_W(2), .CL(CL), .DOORBELL_ADDR(10'h3FF), .IRQ_PULSE(IRQ_PULSE)
  ) dut (
    .CLOCK(clk),
    .RESET(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM port B behavioural model, 1-cycle read latency.
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (bus.BRAM_EN) begin
      if (bus.BRAM_WE) mem[bus.BRAM_ADDR[11:2]] <= bus.BRAM_DIN;
      bus.BRAM_DOUT <= mem[bus.BRAM_ADDR[11:2]];
    end
  end

  typedef struct { logic [15:0] data; int cyc; } rd_exp_t;
  rd_exp_t rd_q[$];

  int tests = 0;
  int fails = 0;

  // reference model state
  logic [31:0] ref_mem [logic [9:0]];
  logic [1:0]  mrow = '0;
  logic [15:0] mhold = '0;
  logic [9:0]  mhaddr = '0;
  logic        mhv = 1'b0;
  logic        mpack = 1'b0;
  logic [7:0]  dcnt = '0;
  int          irq_start = 1;
  int          irq_end = 0;
  logic        mon_exp_oe;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every cycle: OE must match the scoreboard head exactly, and PL_IRQ the model window.
  always @(negedge clk) begin
    mon_exp_oe = (rd_q.size() > 0) && (rd_q[0].cyc == cyc);
    check("rd_oe", {31'd0, bus.EMIF_D_OE}, {31'd0, mon_exp_oe});
    if (mon_exp_oe) begin
      check("rd_data", {16'd0, bus.EMIF_D_OUT}, {16'd0, rd_q[0].data});
      void'(rd_q.pop_front());
    end
    check("pl_irq", {31'd0, bus.PL_IRQ}, {31'd0, (cyc >= irq_start) && (cyc <= irq_end)});
  end

  task automatic drive(input logic ras, input logic cas, input logic wen,
                       input logic [8:0] a, input logic [15:0] d);
    bus.EMIF_RAS_N = ras;
    bus.EMIF_CAS_N = cas;
    bus.EMIF_WEN_N = wen;
    bus.EMIF_A     = a;
    bus.EMIF_D_IN  = d;
    @(negedge clk);
  endtask

  task automatic nop(input int k);
    repeat (k) drive(1'b1, 1'b1, 1'b1, 9'd0, 16'd0);
  endtask

  task automatic act(input logic [1:0] r);
    mrow = r;
    drive(1'b0, 1'b1, 1'b1, {7'd0, r}, 16'd0);
  endtask

  task automatic rd(input logic [8:0] col);
    int n;
    logic [9:0] w;
    logic [31:0] word;
    n = cyc + 1;
    w = {mrow, col[8:1]};
    word = ref_mem[w];
    rd_q.push_back('{data: col[0] ? word[31:16] : word[15:0], cyc: n + CL - 1});
    drive(1'b1, 1'b0, 1'b1, col, 16'd0);
    check("rd_en", {31'd0, bus.BRAM_EN}, 32'd1);
    check("rd_we", {31'd0, bus.BRAM_WE}, 32'd0);
    check("rd_addr", bus.BRAM_ADDR, {20'd0, w, 2'b00});
  endtask

  task automatic wr(input logic [8:0] col, input logic [15:0] d);
    int n;
    logic [9:0] w;
    logic [31:0] word;
    n = cyc + 1;
    w = {mrow, col[8:1]};
    if (!col[0]) begin
      if (mhv) mpack = 1'b1;
      mhold = d; mhaddr = w; mhv = 1'b1;
      drive(1'b1, 1'b0, 1'b0, col, d);
      check("wrlo_no_bram", {31'd0, bus.BRAM_EN}, 32'd0);
    end else begin
      if (mhv && mhaddr == w) begin
        word = {d, mhold}; mhv = 1'b0;
      end else begin
        word = {d, 16'h0000}; mpack = 1'b1;
      end
      ref_mem[w] = word;
      if (w == 10'h3FF) begin
        if (irq_end < n) irq_start = n + 1;
        irq_end = n + IRQ_PULSE;
        dcnt = dcnt + 8'd1;
      end
      drive(1'b1, 1'b0, 1'b0, col, d);
      check("wrhi_en", {31'd0, bus.BRAM_EN}, 32'd1);
      check("wrhi_we", {31'd0, bus.BRAM_WE}, 32'd1);
      check("wrhi_addr", bus.BRAM_ADDR, {20'd0, w, 2'b00});
      check("wrhi_din", bus.BRAM_DIN, word);
    end
    check("pack_err", {31'd0, bus.PACK_ERR}, {31'd0, mpack});
  endtask

  task automatic model_reset();
    mrow = '0; mhv = 1'b0; mpack = 1'b0; dcnt = '0;
    irq_start = 1; irq_end = 0;
    rd_q.delete();
  endtask

  initial begin
    bus.EMIF_RAS_N = 1'b1; bus.EMIF_CAS_N = 1'b1; bus.EMIF_WEN_N = 1'b1;
    bus.EMIF_A = '0; bus.EMIF_D_IN = '0; bus.BRAM_DOUT = '0;
    repeat (2) @(negedge clk);
    // reset state
    check("rst_oe", {31'd0, bus.EMIF_D_OE}, 32'd0);
    check("rst_dout", {16'd0, bus.EMIF_D_OUT}, 32'd0);
    check("rst_en", {31'd0, bus.BRAM_EN}, 32'd0);
    check("rst_we", {31'd0, bus.BRAM_WE}, 32'd0);
    check("rst_addr", bus.BRAM_ADDR, 32'd0);
    check("rst_irq", {31'd0, bus.PL_IRQ}, 32'd0);
    check("rst_pack", {31'd0, bus.PACK_ERR}, 32'd0);
    check("rst_dbcnt", {24'd0, bus.DOORBELL_CNT}, 32'd0);
    rst = 1'b0;
    nop(1);

    // pair write then read
    act(2'd1);
    wr(9'h010, 16'hBEEF);
    wr(9'h011, 16'hDEAD);
    check("pair_din", bus.BRAM_DIN, 32'hDEADBEEF);
    check("pair_addr", bus.BRAM_ADDR, 32'h420);
    nop(1);
    check("pair_en_once", {31'd0, bus.BRAM_EN}, 32'd0);
    rd(9'h011);
    nop(4);

    // back-to-back reads, plus write immediately followed by read of same word
    act(2'd0);
    wr(9'h000, 16'h2222); wr(9'h001, 16'h1111);
    wr(9'h002, 16'h4444); wr(9'h003, 16'h3333);
    nop(2);
    rd(9'h000); rd(9'h001); rd(9'h002); rd(9'h003);
    nop(1);
    wr(9'h004, 16'hAAAA); wr(9'h005, 16'hBBBB);
    rd(9'h005);
    nop(5);

    // orphan high half, overwritten low half
    wr(9'h021, 16'h5555);
    check("orphan_din", bus.BRAM_DIN, 32'h55550000);
    wr(9'h030, 16'hAAAA);
    wr(9'h030, 16'hBBBB);
    wr(9'h031, 16'hCCCC);
    check("overwr_din", bus.BRAM_DIN, 32'hCCCCBBBB);
    // held low half is not forwarded to reads
    act(2'd1);
    wr(9'h010, 16'h1234);
    rd(9'h010);
    wr(9'h011, 16'h5678);
    rd(9'h010);
    nop(5);

    // reset in the middle of a read
    wr(9'h010, 16'h7777);
    rd(9'h011);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    check("midrst_oe", {31'd0, bus.EMIF_D_OE}, 32'd0);
    check("midrst_pack", {31'd0, bus.PACK_ERR}, 32'd0);
    rst = 1'b0;
    nop(4);
    act(2'd1);
    wr(9'h011, 16'h9999);
    check("postrst_orphan", bus.BRAM_DIN, 32'h99990000);
    nop(2);

    // doorbell: single hit, stretch, wrap
    act(2'd3);
    wr(9'h1FE, 16'h0D0D);
    wr(9'h1FF, 16'hB0B0);
    check("db_cnt_pre", {24'd0, bus.DOORBELL_CNT}, 32'd0);
    nop(1);
    check("db_cnt_one", {24'd0, bus.DOORBELL_CNT}, 32'd1);
    wr(9'h1FF, 16'h1111);
    nop(10);
    check("db_cnt_two", {24'd0, bus.DOORBELL_CNT}, {24'd0, dcnt});
    repeat (254) wr(9'h1FF, 16'h2222);
    nop(2);
    check("db_cnt_wrap", {24'd0, bus.DOORBELL_CNT}, 32'd0);
    check("db_cnt_model", {24'd0, bus.DOORBELL_CNT}, {24'd0, dcnt});
    nop(8);
    check("rd_q_drained", rd_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
